// File: rtl/vram_arbiter.sv
// Multi-requester VRAM arbiter: picks one channel per access, drives the
// active-low VRAM bus for ACCESS_CYCLES cycles, then pulses ack to the winner.
module vram_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int ACCESS_CYCLES  = 1,
  parameter int PORT0_PRIORITY = 1
) (
  input  logic                                clk,
  input  logic                                _reset,
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [NUM_PORTS-1:0]                req_wr,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_be,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]                ack,
  output logic [NUM_PORTS-1:0]                grant,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                _vram_en,
  output logic                                _vram_rd,
  output logic                                _vram_wr,
  output logic [DATA_WIDTH/8-1:0]             _vram_be,
  output logic [ADDR_WIDTH-1:0]               vram_addr,
  output logic [DATA_WIDTH-1:0]               vram_wdata,
  output logic                                vram_data_oe,
  input  logic [DATA_WIDTH-1:0]               vram_rdata,
  output logic [1:0]                          dbg_state
);

  // Handshake: a requester raises req[i] with its wr/be/addr/wdata and holds
  // them until ack[i] pulses for one cycle; req is only sampled in IDLE, so
  // changes during an access are ignored and the access always completes.

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]           CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NUM_PORTS - 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [IDX_W-1:0]       win, win_nxt;
  logic [IDX_W-1:0]       last_grant, last_nxt;
  logic                   cur_wr, cur_wr_nxt;

  logic                   en_n_nxt, rd_n_nxt, wr_n_nxt, oe_nxt;
  logic [BE_W-1:0]        be_n_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [DATA_WIDTH-1:0]  wdata_nxt, rdata_nxt;
  logic [NUM_PORTS-1:0]   ack_nxt, grant_nxt;

  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic                   sel_wr;
  logic [BE_W-1:0]        sel_be;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  assign dbg_state = state;

  // Round-robin: first pass covers ports above last_grant, second pass wraps.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    if (PORT0_PRIORITY != 0 && req[0]) begin
      found = 1'b1;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!found && req[p] && (IDX_W'(p) > last_grant)) begin
          pick  = IDX_W'(p);
          found = 1'b1;
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!found && req[p]) begin
          pick  = IDX_W'(p);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick == IDX_W'(p)) begin
        sel_wr    = req_wr[p];
        sel_be    = req_be[p*BE_W +: BE_W];
        sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    win_nxt    = win;
    last_nxt   = last_grant;
    cur_wr_nxt = cur_wr;
    en_n_nxt   = _vram_en;
    rd_n_nxt   = _vram_rd;
    wr_n_nxt   = _vram_wr;
    be_n_nxt   = _vram_be;
    oe_nxt     = vram_data_oe;
    addr_nxt   = vram_addr;
    wdata_nxt  = vram_wdata;
    rdata_nxt  = rdata;
    ack_nxt    = '0;
    grant_nxt  = grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = ACCESS;
          win_nxt    = pick;
          cur_wr_nxt = sel_wr;
          cnt_nxt    = CNT_LOAD;
          grant_nxt  = ONE_HOT0 << pick;
          en_n_nxt   = 1'b0;
          rd_n_nxt   = sel_wr;
          wr_n_nxt   = ~sel_wr;
          be_n_nxt   = ~sel_be;
          oe_nxt     = sel_wr;
          addr_nxt   = sel_addr;
          wdata_nxt  = sel_wdata;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          if (!cur_wr) rdata_nxt = vram_rdata;
          // Releasing the bus here gives DONE its turnaround cycle.
          en_n_nxt  = 1'b1;
          rd_n_nxt  = 1'b1;
          wr_n_nxt  = 1'b1;
          be_n_nxt  = '1;
          oe_nxt    = 1'b0;
          ack_nxt   = grant;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        last_nxt  = win;
        grant_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      win          <= '0;
      last_grant   <= LAST_RST;
      cur_wr       <= 1'b0;
      _vram_en     <= 1'b1;
      _vram_rd     <= 1'b1;
      _vram_wr     <= 1'b1;
      _vram_be     <= '1;
      vram_data_oe <= 1'b0;
      vram_addr    <= '0;
      vram_wdata   <= '0;
      rdata        <= '0;
      ack          <= '0;
      grant        <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      win          <= win_nxt;
      last_grant   <= last_nxt;
      cur_wr       <= cur_wr_nxt;
      _vram_en     <= en_n_nxt;
      _vram_rd     <= rd_n_nxt;
      _vram_wr     <= wr_n_nxt;
      _vram_be     <= be_n_nxt;
      vram_data_oe <= oe_nxt;
      vram_addr    <= addr_nxt;
      vram_wdata   <= wdata_nxt;
      rdata        <= rdata_nxt;
      ack          <= ack_nxt;
      grant        <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: three configurations sharing clock and reset.
module tb_vram_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: 4 ports, 1 access cycle, pure round-robin
  logic [3:0]  a_req, a_req_wr, a_ack, a_grant;
  logic [7:0]  a_req_be;
  logic [63:0] a_req_addr, a_req_wdata;
  logic [15:0] a_rdata, a_addr, a_wdata, a_vram_rdata;
  logic        a_en, a_rd, a_wr, a_oe;
  logic [1:0]  a_be, a_dbg;

  // dut_b: 3 ports, 3 access cycles, port 0 priority
  logic [2:0]  b_req, b_req_wr, b_ack, b_grant;
  logic [5:0]  b_req_be;
  logic [47:0] b_req_addr, b_req_wdata;
  logic [15:0] b_rdata, b_addr, b_wdata, b_vram_rdata;
  logic        b_en, b_rd, b_wr, b_oe;
  logic [1:0]  b_be, b_dbg;

  // dut_c: 2 ports, 4 access cycles, port 0 priority
  logic [1:0]  c_req, c_req_wr, c_ack, c_grant;
  logic [3:0]  c_req_be;
  logic [31:0] c_req_addr, c_req_wdata;
  logic [15:0] c_rdata, c_addr, c_wdata, c_vram_rdata;
  logic        c_en, c_rd, c_wr, c_oe;
  logic [1:0]  c_be, c_dbg;

  vram_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                 .ACCESS_CYCLES(1), .PORT0_PRIORITY(0)) dut_a (
    .clk(clk), ._reset(rst_n), .req(a_req), .req_wr(a_req_wr), .req_be(a_req_be),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .ack(a_ack), .grant(a_grant),
    .rdata(a_rdata), ._vram_en(a_en), ._vram_rd(a_rd), ._vram_wr(a_wr), ._vram_be(a_be),
    .vram_addr(a_addr), .vram_wdata(a_wdata), .vram_data_oe(a_oe),
    .vram_rdata(a_vram_rdata), .dbg_state(a_dbg));

  vram_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                 .ACCESS_CYCLES(3), .PORT0_PRIORITY(1)) dut_b (
    .clk(clk), ._reset(rst_n), .req(b_req), .req_wr(b_req_wr), .req_be(b_req_be),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .ack(b_ack), .grant(b_grant),
    .rdata(b_rdata), ._vram_en(b_en), ._vram_rd(b_rd), ._vram_wr(b_wr), ._vram_be(b_be),
    .vram_addr(b_addr), .vram_wdata(b_wdata), .vram_data_oe(b_oe),
    .vram_rdata(b_vram_rdata), .dbg_state(b_dbg));

  vram_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                 .ACCESS_CYCLES(4), .PORT0_PRIORITY(1)) dut_c (
    .clk(clk), ._reset(rst_n), .req(c_req), .req_wr(c_req_wr), .req_be(c_req_be),
    .req_addr(c_req_addr), .req_wdata(c_req_wdata), .ack(c_ack), .grant(c_grant),
    .rdata(c_rdata), ._vram_en(c_en), ._vram_rd(c_rd), ._vram_wr(c_wr), ._vram_be(c_be),
    .vram_addr(c_addr), .vram_wdata(c_wdata), .vram_data_oe(c_oe),
    .vram_rdata(c_vram_rdata), .dbg_state(c_dbg));

  task automatic clear_inputs();
    a_req = '0; a_req_wr = '0; a_req_be = '1; a_req_addr = '0; a_req_wdata = '0; a_vram_rdata = '0;
    b_req = '0; b_req_wr = '0; b_req_be = '1; b_req_addr = '0; b_req_wdata = '0; b_vram_rdata = '0;
    c_req = '0; c_req_wr = '0; c_req_be = '1; c_req_addr = '0; c_req_wdata = '0; c_vram_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_en, a_rd, a_wr, a_be, a_oe, a_ack, a_grant, a_rdata, a_addr, a_dbg} !==
          {3'b111, 2'b11, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 2'd0}) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: en/rd/wr=%b%b%b be=%b oe=%b ack=%b grant=%b rdata=%h addr=%h st=%0d, required 111 11 0 0000 0000 0000 0000 0",
                 i, a_en, a_rd, a_wr, a_be, a_oe, a_ack, a_grant, a_rdata, a_addr, a_dbg);
      end
    end
    n_cmp++;
    if ({b_en, b_rd, b_wr, b_be, b_oe, b_ack, b_grant, b_rdata} !== {3'b111, 2'b11, 1'b0, 3'b0, 3'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_b: en/rd/wr=%b%b%b be=%b oe=%b ack=%b grant=%b rdata=%h", b_en, b_rd, b_wr, b_be, b_oe, b_ack, b_grant, b_rdata);
    end
    n_cmp++;
    if ({c_en, c_rd, c_wr, c_be, c_oe, c_ack, c_grant, c_rdata} !== {3'b111, 2'b11, 1'b0, 2'b0, 2'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_c: en/rd/wr=%b%b%b be=%b oe=%b ack=%b grant=%b rdata=%h", c_en, c_rd, c_wr, c_be, c_oe, c_ack, c_grant, c_rdata);
    end
  endtask

  task automatic test_single_read();
    a_req_addr[31:16] = 16'h1234;
    a_req_wr[1]       = 1'b0;
    a_vram_rdata      = 16'hBEEF;
    a_req[1]          = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_en, a_rd, a_wr, a_oe, a_addr, a_grant, a_ack} !== {4'b0010, 16'h1234, 4'b0010, 4'b0000}) begin
      n_bad++;
      $display("FAIL read_access: en/rd/wr/oe=%b%b%b%b addr=%h grant=%b ack=%b, required 0010 1234 0010 0000",
               a_en, a_rd, a_wr, a_oe, a_addr, a_grant, a_ack);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_en, a_rd, a_wr, a_ack, a_grant, a_rdata} !== {3'b111, 4'b0010, 4'b0010, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL read_done: en/rd/wr=%b%b%b ack=%b grant=%b rdata=%h, required 111 0010 0010 beef",
               a_en, a_rd, a_wr, a_ack, a_grant, a_rdata);
    end
    a_req        = '0;
    a_vram_rdata = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if ({a_en, a_ack, a_grant, a_rdata} !== {1'b1, 4'b0000, 4'b0000, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL read_idle: en=%b ack=%b grant=%b rdata=%h, required 1 0000 0000 beef", a_en, a_ack, a_grant, a_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    a_req = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      exp_g = 4'b0001 << (k % 3 + 1);
      for (int g = 0; g < 20 && a_grant == 4'b0; g++) @(negedge clk);
      n_cmp++;
      if (a_grant !== exp_g) begin
        n_bad++;
        $display("FAIL round_robin #%0d: grant=%b, required %b", k, a_grant, exp_g);
      end
      for (int g = 0; g < 20 && a_grant != 4'b0; g++) @(negedge clk);
    end
    a_req = '0;
  endtask

  task automatic test_write_wait();
    b_req_addr[15:0]  = 16'h0800;
    b_req_wdata[15:0] = 16'hA55A;
    b_req_be[1:0]     = 2'b01;
    b_req_wr[0]       = 1'b1;
    b_req[0]          = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_en, b_rd, b_wr, b_be, b_oe, b_addr, b_wdata, b_ack, b_grant} !==
          {3'b010, 2'b10, 1'b1, 16'h0800, 16'hA55A, 3'b000, 3'b001}) begin
        n_bad++;
        $display("FAIL write_access cyc %0d: en/rd/wr=%b%b%b be=%b oe=%b addr=%h wdata=%h ack=%b grant=%b, required 010 10 1 0800 a55a 000 001",
                 i, b_en, b_rd, b_wr, b_be, b_oe, b_addr, b_wdata, b_ack, b_grant);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({b_en, b_wr, b_oe, b_ack, b_grant, b_rdata} !== {3'b110, 3'b001, 3'b001, 16'h0000}) begin
      n_bad++;
      $display("FAIL write_done: en/wr/oe=%b%b%b ack=%b grant=%b rdata=%h, required 110 001 001 0000",
               b_en, b_wr, b_oe, b_ack, b_grant, b_rdata);
    end
    b_req    = '0;
    b_req_wr = '0;
    @(negedge clk);
    n_cmp++;
    if ({b_ack, b_grant} !== 6'b0) begin
      n_bad++;
      $display("FAIL write_idle: ack=%b grant=%b, required 000 000", b_ack, b_grant);
    end
  endtask

  task automatic test_port0_priority();
    b_req = 3'b101;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 20 && b_grant == 3'b0; g++) @(negedge clk);
      n_cmp++;
      if (b_grant !== 3'b001) begin
        n_bad++;
        $display("FAIL port0_priority #%0d: grant=%b, required 001", k, b_grant);
      end
      for (int g = 0; g < 20 && b_grant != 3'b0; g++) @(negedge clk);
    end
    b_req = 3'b100;
    for (int g = 0; g < 20 && b_grant == 3'b0; g++) @(negedge clk);
    n_cmp++;
    if (b_grant !== 3'b100) begin
      n_bad++;
      $display("FAIL port2_after_release: grant=%b, required 100", b_grant);
    end
    for (int g = 0; g < 20 && b_grant != 3'b0; g++) @(negedge clk);
    b_req = '0;
  endtask

  task automatic test_reset_mid_access();
    c_req_addr[31:16] = 16'h0042;
    c_req_wr[1]       = 1'b0;
    c_vram_rdata      = 16'h1357;
    c_req[1]          = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({c_en, c_rd, c_grant} !== {2'b00, 2'b10}) begin
      n_bad++;
      $display("FAIL mid_first_access: en/rd=%b%b grant=%b, required 00 10", c_en, c_rd, c_grant);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({c_en, c_rd, c_wr, c_be, c_grant, c_ack, c_dbg} !== {3'b111, 2'b11, 2'b00, 2'b00, 2'd0}) begin
      n_bad++;
      $display("FAIL mid_async_reset: en/rd/wr=%b%b%b be=%b grant=%b ack=%b st=%0d, required 111 11 00 00 0",
               c_en, c_rd, c_wr, c_be, c_grant, c_ack, c_dbg);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (c_ack !== 2'b00) begin
        n_bad++;
        $display("FAIL mid_no_ack cyc %0d: ack=%b, required 00", i, c_ack);
      end
    end
    rst_n = 1'b1;
    for (int g = 0; g < 20 && c_grant == 2'b0; g++) @(negedge clk);
    n_cmp++;
    if ({c_grant, c_en, c_rd, c_addr, c_rdata} !== {2'b10, 2'b00, 16'h0042, 16'h0000}) begin
      n_bad++;
      $display("FAIL post_reset_access: grant=%b en/rd=%b%b addr=%h rdata=%h, required 10 00 0042 0000",
               c_grant, c_en, c_rd, c_addr, c_rdata);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({c_ack, c_en, c_rdata} !== {2'b10, 1'b1, 16'h1357}) begin
      n_bad++;
      $display("FAIL post_reset_ack: ack=%b en=%b rdata=%h, required 10 1 1357", c_ack, c_en, c_rdata);
    end
    c_req = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wait();
    test_port0_priority();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at time %0t, required finish", $time);
    $fatal(1);
  end

endmodule
